seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector. It samples a 1-bit stream `din` qualified by `din_valid` and matches it against a runtime-loadable `PAT_LEN`-bit pattern. Overlapping or non-overlapping matching is selectable at runtime, and a saturating match counter is kept. It sits downstream of a serial receiver and upstream of event/interrupt logic, and replaces the fixed-pattern, fixed-mode detector used in earlier designs.

## Interface
- `PAT_LEN`, 4: pattern length in bits; legal range ≥ 2.
- `CNT_W`, 8: width of the match counter.
- `PAT_RESET`, 4'b1011: pattern value loaded at reset; `PAT_LEN` bits wide.
- `OVL_RESET`, 1: overlap mode loaded at reset.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `din`, in, 1: serial data bit.
- `din_valid`, in, 1: `din` is sampled only when this is 1.
- `cfg_we`, in, 1: load `cfg_pattern` and `cfg_overlap`.
- `cfg_pattern`, in, `PAT_LEN`: new pattern. The MSB is the first bit received.
- `cfg_overlap`, in, 1: 1 = overlapping, 0 = non-overlapping.
- `cnt_clr`, in, 1: clear the match counter.
- `y`, out, 1: match pulse, registered, one cycle wide.
- `match_count`, out, `CNT_W`: saturating count of matches.
- `count_sat`, out, 1: high while `match_count` equals 2^`CNT_W`−1.

## Operation
- **Internal state**
  - `pat_reg[PAT_LEN-1:0]` and `ovl_reg`.
  - History shift register `hist[PAT_LEN-1:0]`; the newest bit sits at the LSB.
  - Fill counter `fill`, range 0..`PAT_LEN`, saturating.
- **Sample** (`din_valid`=1 and `cfg_we`=0):
  - `hist <= {hist[PAT_LEN-2:0], din}`.
  - `fill <= min(fill+1, PAT_LEN)`.
- **Match condition**: a sample cycle in which `fill ≥ PAT_LEN-1` and `{hist[PAT_LEN-2:0], din} == pat_reg`.
- **On a match**
  - `y <= 1`.
  - Counter increments, unless already saturated.
  - `ovl_reg`=1: `fill` saturates at `PAT_LEN` as normal, so a suffix of the match can start the next match.
  - `ovl_reg`=0: `fill <= 0`, so the next match needs `PAT_LEN` fresh valid bits.
- **`y` when there is no match**: `y <= 0` every cycle without a match, including cycles where `din_valid`=0.
- **`din_valid`=0**: `hist` and `fill` hold. Gaps in the stream are transparent.
- **`cfg_we`=1** (priority over sampling):
  - `pat_reg <= cfg_pattern`, `ovl_reg <= cfg_overlap`.
  - `fill <= 0`, `y <= 0`.
  - `din` in that cycle is discarded.
  - `match_count` is unaffected.
- **Counter**
  - `cnt_clr`=1 without a match → 0.
  - `cnt_clr`=1 together with a match → 1, so no match is lost.
  - At 2^`CNT_W`−1 the counter holds; `count_sat`=1 is derived combinationally from the count.
- **Reset** (`rst`=1, any cycle, including mid-pattern):
  - `hist`=0, `fill`=0, `y`=0, `match_count`=0, `count_sat`=0.
  - `pat_reg`=`PAT_RESET`, `ovl_reg`=`OVL_RESET`.
  - All other inputs are ignored while reset is asserted.

## Timing
- Latency: `y` rises on the clock edge that samples the completing bit and stays high for exactly one cycle. There is no combinational path from `din` to `y`.
- `match_count` updates on the same edge as `y` rises; `count_sat` follows the count with no extra delay.
- Back-to-back matches, e.g. pattern 1111 in overlap mode fed with all ones, give `y` high on consecutive cycles.
- The first possible match follows `PAT_LEN` valid samples after reset or `cfg_we`.
- `cfg_we` asserted on the same edge as a completing bit suppresses that match.
- The new pattern applies from the next valid sample.

## Test plan
- **Reset values**: hold `rst`=1 for 2 cycles → `y`=0, `match_count`=0, `count_sat`=0. Then send 1,0,1,1 with valid → `y` pulses one cycle after the 4th bit and `match_count`=1.
- **Overlap mode**: `PAT_LEN`=4, pattern 1011, `ovl`=1, stream 1011011 → `y` pulses after bits 4 and 7, `match_count`=2.
- **Non-overlap mode**: same setup with `ovl`=0.
  - Stream 1011011 → a single pulse after bit 4, `match_count`=1.
  - Stream 10111011 → pulses after bits 4 and 8.
- **Valid gaps**: stream 1,0,1,1 with `din_valid` low for 3 cycles between each bit, and junk on `din` during the gaps → exactly one pulse after the final valid bit.
- **Counter**: `CNT_W`=2, five matches → `match_count`=3, `count_sat`=1. Then `cnt_clr` on the cycle of a match → `match_count`=1, `count_sat`=0.
- **Reset and reconfiguration mid-pattern**:
  - Send 1,0,1, assert `rst` for 1 cycle, then send 1 → no pulse.
  - Send 1,0,1, pulse `cfg_we` with pattern 0110, then send 1 → no pulse.
  - Then send 0,1,1,0 → pulse after the last bit.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Serial pattern detector with a runtime-loadable pattern, runtime-selectable
// overlapping / non-overlapping matching and a saturating match counter.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   din          : serial data bit
//   din_valid    : din is sampled only when high
//   cfg_we       : load cfg_pattern / cfg_overlap (wins over sampling)
//   cfg_pattern  : new pattern, MSB is the first bit received
//   cfg_overlap  : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      : clear the match counter
//   y            : registered one-cycle match pulse
//   match_count  : saturating match count
//   count_sat    : high while match_count is at its maximum

module seq_detector_param #(
   parameter int                 PAT_LEN   = 4,
   parameter int                 CNT_W     = 8,
   parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011,
   parameter logic               OVL_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_we,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MIN  = FILL_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [PAT_LEN-1:0] pat_reg;
   logic               ovl_reg;
   logic [PAT_LEN-1:0] hist;
   logic [FILL_W-1:0]  fill;

   logic               sample;
   logic [PAT_LEN-1:0] hist_next;
   logic               match;

   // The completing bit is compared before it lands in hist, so y can be
   // registered on the same edge that samples it.
   assign sample    = din_valid & ~cfg_we;
   assign hist_next = {hist[PAT_LEN-2:0], din};
   assign match     = sample && (fill >= FILL_MIN) && (hist_next == pat_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_reg <= PAT_RESET;
         ovl_reg <= OVL_RESET;
         hist    <= '0;
         fill    <= '0;
         y       <= 1'b0;
      end else begin
         y <= match;
         if (cfg_we) begin
            pat_reg <= cfg_pattern;
            ovl_reg <= cfg_overlap;
            fill    <= '0;
         end else if (din_valid) begin
            hist <= hist_next;
            if (match && !ovl_reg)
               fill <= '0;
            else if (fill != FILL_FULL)
               fill <= fill + FILL_W'(1);
         end
      end
   end

   // A clear coinciding with a match leaves a count of one so the match
   // is not lost.
   always_ff @(posedge clk) begin
      if (rst)
         match_count <= '0;
      else if (cnt_clr)
         match_count <= match ? CNT_W'(1) : '0;
      else if (match && match_count != CNT_MAX)
         match_count <= match_count + CNT_W'(1);
   end

   assign count_sat = (match_count == CNT_MAX);

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

   localparam int PAT_LEN = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               din = 1'b0;
   logic               din_valid = 1'b0;
   logic               cfg_we = 1'b0;
   logic [PAT_LEN-1:0] cfg_pattern = '0;
   logic               cfg_overlap = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               y;
   logic [CNT_W-1:0]   match_count;
   logic               count_sat;

   int n_cmp = 0;
   int n_bad = 0;

   seq_detector_param #(
      .PAT_LEN  (PAT_LEN),
      .CNT_W    (CNT_W),
      .PAT_RESET(4'b1011),
      .OVL_RESET(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .cfg_we     (cfg_we),
      .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap),
      .cnt_clr    (cnt_clr),
      .y          (y),
      .match_count(match_count),
      .count_sat  (count_sat)
   );

   always #5 clk = ~clk;

   // Behavioural model: keep the valid bits received since the last restart
   // (reset, reconfiguration, or a non-overlapping match) and look for the
   // pattern in the newest PAT_LEN of them.
   bit                 started = 1'b0;
   bit                 win[$];
   logic [PAT_LEN-1:0] m_pat = 4'b1011;
   bit                 m_ovl = 1'b1;
   bit                 m_y = 1'b0;
   int                 m_cnt = 0;

   always @(posedge clk) begin
      bit hit;
      hit = 1'b0;
      if (rst) begin
         started = 1'b1;
         win.delete();
         m_pat = 4'b1011;
         m_ovl = 1'b1;
         m_y   = 1'b0;
         m_cnt = 0;
      end else if (cfg_we) begin
         m_pat = cfg_pattern;
         m_ovl = cfg_overlap;
         win.delete();
         m_y = 1'b0;
         if (cnt_clr) m_cnt = 0;
      end else begin
         if (din_valid) begin
            win.push_back(din);
            if (win.size() > PAT_LEN) void'(win.pop_front());
            if (win.size() == PAT_LEN) begin
               hit = 1'b1;
               for (int i = 0; i < PAT_LEN; i++)
                  if (win[i] != m_pat[PAT_LEN-1-i]) hit = 1'b0;
            end
            if (hit && !m_ovl) win.delete();
         end
         m_y = hit;
         if (cnt_clr)
            m_cnt = hit ? 1 : 0;
         else if (hit && m_cnt < CNT_MAX)
            m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         n_cmp++;
         if (y !== m_y || int'(match_count) != m_cnt || count_sat !== (m_cnt == CNT_MAX)) begin
            n_bad++;
            $display("FAIL model t=%0t: y=%b cnt=%0d sat=%b, required y=%b cnt=%0d sat=%b",
                     $time, y, match_count, count_sat, m_y, m_cnt, (m_cnt == CNT_MAX));
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one valid bit for one cycle and check y just after the edge.
   task automatic send(input logic b, input int exp_y, input string name);
      din       = b;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din       = 1'($urandom_range(0, 1));
      chk(name, int'(y), exp_y);
   endtask

   task automatic send4(input logic [3:0] bits, input logic [3:0] ey, input string name);
      for (int i = 3; i >= 0; i--) send(bits[i], int'(ey[i]), name);
   endtask

   task automatic cfg(input logic [PAT_LEN-1:0] p, input logic o);
      cfg_we      = 1'b1;
      cfg_pattern = p;
      cfg_overlap = o;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic clr();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   initial begin
      tick();
      // Reset values
      rst = 1'b1;
      din = 1'b1; din_valid = 1'b1; cfg_we = 1'b1; cfg_pattern = 4'b0000;
      tick();
      tick();
      rst = 1'b0; din_valid = 1'b0; cfg_we = 1'b0;
      chk("rst_y", int'(y), 0);
      chk("rst_cnt", int'(match_count), 0);
      chk("rst_sat", int'(count_sat), 0);
      send4(4'b1011, 4'b0001, "rst_first_match");
      tick();
      chk("rst_first_y_one_cycle", int'(y), 0);
      chk("rst_first_cnt", int'(match_count), 1);

      // Overlap mode: 1011011 -> pulses after bits 4 and 7
      cfg(4'b1011, 1'b1);
      clr();
      send4(4'b1011, 4'b0001, "ovl_a");
      send(1'b0, 0, "ovl_b5");
      send(1'b1, 0, "ovl_b6");
      send(1'b1, 1, "ovl_b7");
      chk("ovl_cnt", int'(match_count), 2);

      // Non-overlap mode: 1011011 -> one pulse
      cfg(4'b1011, 1'b0);
      clr();
      send4(4'b1011, 4'b0001, "novl_a");
      send(1'b0, 0, "novl_b5");
      send(1'b1, 0, "novl_b6");
      send(1'b1, 0, "novl_b7");
      chk("novl_cnt1", int'(match_count), 1);
      // 10111011 -> pulses after bits 4 and 8
      cfg(4'b1011, 1'b0);
      clr();
      send4(4'b1011, 4'b0001, "novl_c");
      send4(4'b1011, 4'b0001, "novl_d");
      chk("novl_cnt2", int'(match_count), 2);

      // Valid gaps with junk on din
      cfg(4'b1011, 1'b1);
      clr();
      begin
         logic [3:0] bits;
         bits = 4'b1011;
         for (int i = 3; i >= 0; i--) begin
            send(bits[i], (i == 0) ? 1 : 0, "gap_bit");
            for (int g = 0; g < 3; g++) begin
               din = 1'($urandom_range(0, 1));
               tick();
               chk("gap_idle", int'(y), 0);
            end
         end
      end
      chk("gap_cnt", int'(match_count), 1);

      // Counter saturation with back-to-back matches on 1111
      cfg(4'b1111, 1'b1);
      clr();
      chk("clr_cnt", int'(match_count), 0);
      send4(4'b1111, 4'b0001, "b2b_a");
      for (int i = 0; i < 4; i++) send(1'b1, 1, "b2b_run");
      chk("sat_cnt", int'(match_count), 3);
      chk("sat_flag", int'(count_sat), 1);
      cnt_clr = 1'b1;
      send(1'b1, 1, "clr_with_match_y");
      cnt_clr = 1'b0;
      chk("clr_with_match_cnt", int'(match_count), 1);
      chk("clr_with_match_sat", int'(count_sat), 0);

      // Reset mid-pattern
      cfg(4'b1011, 1'b1);
      send(1'b1, 0, "mid_rst_a");
      send(1'b0, 0, "mid_rst_b");
      send(1'b1, 0, "mid_rst_c");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(1'b1, 0, "mid_rst_no_pulse");
      chk("mid_rst_cnt", int'(match_count), 0);

      // Reconfiguration mid-pattern; din during cfg_we is discarded
      rst = 1'b1; tick(); rst = 1'b0;
      send(1'b1, 0, "mid_cfg_a");
      send(1'b0, 0, "mid_cfg_b");
      send(1'b1, 0, "mid_cfg_c");
      din = 1'b1; din_valid = 1'b1;
      cfg(4'b0110, 1'b1);
      din_valid = 1'b0;
      chk("cfg_edge_y", int'(y), 0);
      send(1'b1, 0, "mid_cfg_no_pulse");
      send4(4'b0110, 4'b0001, "new_pat");

      // cfg_we on the completing edge suppresses the match
      cfg(4'b1011, 1'b1);
      send(1'b1, 0, "sup_a");
      send(1'b0, 0, "sup_b");
      send(1'b1, 0, "sup_c");
      din = 1'b1; din_valid = 1'b1;
      cfg(4'b1011, 1'b1);
      din_valid = 1'b0;
      chk("sup_y", int'(y), 0);
      send(1'b1, 0, "sup_after");
      chk("sup_cnt", int'(match_count), 1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
